// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared state encoding and constants for the FIFO burst reader.
package fifo_reader_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} rd_state_t;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry register FIFO absorbing FIFO read latency and stream backpressure.
module fifo_reader_skid import fifo_reader_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = SKID_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);
  logic [DATA_WIDTH-1:0] e0, e1;
  if (DEPTH != 2) begin : g_depth_check
    $error("fifo_reader_skid: DEPTH must be 2");
  end
  assign head = e0;
  // e0 is always the head; e1 only holds a word when two are buffered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      e0    <= '0;
      e1    <= '0;
      count <= '0;
    end else begin
      if (pop) e0 <= (count == 2'd2) ? e1 : din;
      else if (push && count == 2'd0) e0 <= din;
      if (push && (pop ? count == 2'd2 : count == 2'd1)) e1 <= din;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains burst_len FIFO words into a valid/ready stream, flagging the last.
// Define FIFO_BURST_READER_AE_THROTTLE_EN to allow only one outstanding read while almost empty.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_W = 8,
  parameter int SKID_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BURST_W-1:0]    burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic                  fifo_underflow,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  err_underflow
);
  import fifo_reader_pkg::*;
  rd_state_t state, state_nxt;
  logic [BURST_W-1:0] rem_issue, rem_deliver;
  logic [1:0] skid_count;
  logic [2:0] outstanding;
  logic inflight, capture, pop, deliver_end, throttle_ok;
  assign capture     = inflight && !fifo_underflow;
  assign pop         = m_valid && m_ready;
  assign outstanding = {1'b0, skid_count} + {2'b0, inflight};
  assign deliver_end = rem_deliver == '0 || (pop && rem_deliver == BURST_W'(1));
`ifdef FIFO_BURST_READER_AE_THROTTLE_EN
  assign throttle_ok = !(fifo_almost_empty && inflight);
`else
  logic unused_almost_empty;
  assign unused_almost_empty = fifo_almost_empty;
  assign throttle_ok = 1'b1;
`endif
  // rem_issue only drops on capture, so a read still in flight must count against it
  assign fifo_read_enable = state == RUN && !fifo_empty && rem_issue > {{(BURST_W-1){1'b0}}, inflight}
                            && outstanding < 3'd2 && throttle_ok;
  assign busy    = state == RUN || state == FLUSH;
  assign done    = state == DONE;
  assign m_valid = skid_count != 2'd0;
  assign m_last  = m_valid && rem_deliver == BURST_W'(1);
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? (burst_len == '0 ? DONE : RUN) : IDLE;
      RUN:     state_nxt = rem_issue == '0 ? (deliver_end ? DONE : FLUSH) : RUN;
      FLUSH:   state_nxt = deliver_end ? DONE : FLUSH;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      rem_issue     <= '0;
      rem_deliver   <= '0;
      inflight      <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state         <= state_nxt;
      rem_issue     <= (state == IDLE && start) ? burst_len : capture ? rem_issue - BURST_W'(1) : rem_issue;
      rem_deliver   <= (state == IDLE && start) ? burst_len : pop ? rem_deliver - BURST_W'(1) : rem_deliver;
      inflight      <= fifo_read_enable;
      err_underflow <= err_underflow || (fifo_underflow && busy);
    end
  fifo_reader_skid #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(SKID_DEPTH)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .pop   (pop),
    .din   (fifo_data_out),
    .count (skid_count),
    .head  (m_data)
  );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: randomized bench with a queue-based FIFO and stream reference model.
module tb_fifo_burst_reader;
  localparam int DW = 16;
  localparam int BW = 8;
  logic clk = 1'b0;
  logic rst, start, busy, done, fifo_read_enable, fifo_empty, fifo_almost_empty, fifo_underflow;
  logic m_valid, m_ready, m_last, err_underflow;
  logic [BW-1:0] burst_len;
  logic [DW-1:0] fifo_data_out, m_data;
  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_W(BW), .SKID_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .burst_len(burst_len), .busy(busy), .done(done),
    .fifo_read_enable(fifo_read_enable), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_almost_empty(fifo_almost_empty), .fifo_underflow(fifo_underflow), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .err_underflow(err_underflow)
  );

  int tests = 0, fails = 0;
  logic [DW-1:0] q[$], exp_q[$];
  int sched[$];
  logic [DW-1:0] next_word = 16'h0001;
  int cyc, ready_mode, uf_read, poke_cyc, n_cur;
  int reads, good_reads, inj_cnt, delivered, dones, last_xfer_cyc, done_cyc;
  logic prev_stall, prev_last, prev_inj, valid_seen;
  logic [DW-1:0] prev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic write_word();
    q.push_back(next_word);
    exp_q.push_back(next_word);
    next_word++;
  endtask

  task automatic set_flags();
    fifo_empty = q.size() == 0;
    fifo_almost_empty = q.size() <= 1;
  endtask

  // one clock: sample at negedge, advance FIFO model just after posedge, return at negedge
  task automatic tick();
    logic re, xfer, inj;
    int outst;
    re = fifo_read_enable;
    xfer = m_valid && m_ready;
    inj = re && reads == uf_read;
    if (m_valid) valid_seen = 1'b1;
    if (re) begin
      outst = good_reads - delivered + (prev_inj ? 1 : 0);
      check("rd_when_empty", fifo_empty, 0);
      check("rd_outstanding", outst + 1 <= 2, 1);
      reads++;
      if (inj) inj_cnt++;
      else good_reads++;
    end
    if (prev_stall) begin
      check("stall_valid", m_valid, 1);
      check("stall_data", m_data, prev_data);
      check("stall_last", m_last, prev_last);
    end
    if (xfer) begin
      if (exp_q.size() == 0) check("data_extra", 1, 0);
      else check("data", m_data, exp_q.pop_front());
      check("last", m_last, delivered == n_cur - 1);
      delivered++;
      last_xfer_cyc = cyc;
    end
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    prev_stall = m_valid && !m_ready;
    prev_data = m_data;
    prev_last = m_last;
    prev_inj = inj;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    fifo_underflow = 1'b0;
    if (re) begin
      if (inj || q.size() == 0) begin
        fifo_underflow = 1'b1;
        fifo_data_out = 16'hDEAD;
      end else fifo_data_out = q.pop_front();
    end
    while (sched.size() != 0 && sched[0] <= cyc) begin
      void'(sched.pop_front());
      write_word();
    end
    set_flags();
    m_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
    if (cyc == poke_cyc) begin
      start = 1'b1;
      burst_len = 8'd77;
    end
    @(negedge clk);
  endtask

  task automatic begin_burst(input int n, input int mode, input int uf);
    n_cur = n;
    ready_mode = mode;
    uf_read = uf;
    cyc = 0;
    reads = 0;
    good_reads = 0;
    inj_cnt = 0;
    delivered = 0;
    dones = 0;
    valid_seen = 1'b0;
    last_xfer_cyc = 0;
    done_cyc = 0;
    m_ready = 1'b1;
    start = 1'b1;
    burst_len = BW'(n);
  endtask

  task automatic burst(input int n, input int mode, input int uf);
    begin_burst(n, mode, uf);
    for (int i = 0; i < 600 && dones == 0; i++) tick();
    check("done_seen", dones, 1);
    check("delivered", delivered, n);
    check("reads", reads, n + inj_cnt);
    if (n > 0) check("done_lat", done_cyc - last_xfer_cyc, 1);
    else begin
      check("done_lat0", done_cyc, 1);
      check("zero_valid", valid_seen, 0);
    end
    ready_mode = 0;
    tick();
    check("done_once", dones, 1);
    check("busy_after", busy, 0);
    check("valid_after", m_valid, 0);
    poke_cyc = -1;
  endtask

  task automatic clear_fifo();
    q.delete();
    exp_q.delete();
    set_flags();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    burst_len = '0;
    fifo_data_out = '0;
    fifo_underflow = 1'b0;
    m_ready = 1'b0;
    poke_cyc = -1;
    uf_read = -1;
    prev_stall = 1'b0;
    prev_inj = 1'b0;
    set_flags();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_re", fifo_read_enable, 0);
    check("rst_err", err_underflow, 0);
    check("rst_data", m_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    // preload 1..4, full-rate drain
    repeat (4) write_word();
    set_flags();
    burst(4, 0, -1);
    check("err_clean", err_underflow, 0);
    burst(0, 0, -1);
    // 8 words, burst 6, ready 1,0,0 pattern, stray start mid-burst
    repeat (8) write_word();
    set_flags();
    poke_cyc = 4;
    burst(6, 1, -1);
    check("left_in_fifo", q.size(), 2);
    // empty FIFO, words trickle in
    clear_fifo();
    sched = '{5, 9, 10};
    burst(3, 0, -1);
    // second read returns underflow and must be retried
    clear_fifo();
    repeat (4) write_word();
    set_flags();
    burst(4, 0, 1);
    check("err_set", err_underflow, 1);
    for (int b = 0; b < 20; b++) begin
      int n, p;
      n = $urandom_range(1, 12);
      p = $urandom_range(0, n);
      repeat (p) write_word();
      set_flags();
      begin
        int c = 0;
        for (int k = 0; k < n - p + $urandom_range(0, 2); k++) begin
          c += $urandom_range(1, 4);
          sched.push_back(c);
        end
      end
      burst(n, $urandom_range(0, 2), -1);
      sched.delete();
    end
    check("err_sticky", err_underflow, 1);
    // reset mid-burst after two words
    clear_fifo();
    repeat (5) write_word();
    set_flags();
    begin_burst(5, 0, -1);
    for (int i = 0; i < 100 && delivered < 2; i++) tick();
    check("pre_rst_delivered", delivered, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_re", fifo_read_enable, 0);
    check("mid_rst_err", err_underflow, 0);
    check("mid_rst_last", m_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fifo_underflow = 1'b0;
    exp_q = q;
    prev_stall = 1'b0;
    prev_inj = 1'b0;
    @(negedge clk);
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);
    write_word();
    set_flags();
    burst(1, 0, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
